// File: rtl/pen_matrix_scanner_if.sv
// Pen matrix scanner bundle: scan control, matrix drive, pen hit events and LCD-mirror read port.
// The master side drives control, pen and read address. The slave side drives the matrix, events and read data.
interface pen_matrix_scanner_if #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int COLOR_W = 2
);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);

  logic                    en_i;
  logic [1:0]              mode_i;
  logic [COLOR_W-1:0]      color_i;
  logic                    pen_i;
  logic                    clear_i;
  logic [RW-1:0]           rd_row_i;
  logic [CLW-1:0]          rd_col_i;
  logic [ROWS-1:0]         row_o;
  logic [COLS*COLOR_W-1:0] col_o;
  logic                    pen_valid_o;
  logic [RW-1:0]           pen_row_o;
  logic [CLW-1:0]          pen_col_o;
  logic                    busy_o;
  logic [COLOR_W-1:0]      rd_data_o;

  modport master (
    output en_i, mode_i, color_i, pen_i, clear_i, rd_row_i, rd_col_i,
    input  row_o, col_o, pen_valid_o, pen_row_o, pen_col_o, busy_o, rd_data_o
  );

  modport slave (
    input  en_i, mode_i, color_i, pen_i, clear_i, rd_row_i, rd_col_i,
    output row_o, col_o, pen_valid_o, pen_row_o, pen_col_o, busy_o, rd_data_o
  );
endinterface

// File: rtl/pen_matrix_scanner.sv
// Time-multiplexed dot-matrix driver: per-row display phase, then per-pixel probe slots that locate a light pen.
// Pen hits pulse one cycle after the filter latches and update the framebuffer. Reads have 1-cycle latency. No backpressure.
module pen_matrix_scanner #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int COLOR_W    = 2,
  parameter int DISP_CYC   = 2000,
  parameter int PROBE_CYC  = 200,
  parameter int PEN_SETTLE = 50,
  parameter int PEN_HITS   = 20
) (
  input logic           clk,
  input logic           rst,
  pen_matrix_scanner_if.slave bus
);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int TW  = $clog2(((DISP_CYC > PROBE_CYC) ? DISP_CYC : PROBE_CYC) + 1);
  localparam int HW  = $clog2(PEN_HITS + 1);
  localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CLW-1:0] COL_LAST   = CLW'(COLS - 1);
  localparam logic [TW-1:0]  DISP_LAST  = TW'(DISP_CYC - 1);
  localparam logic [TW-1:0]  PROBE_LAST = TW'(PROBE_CYC - 1);
  localparam logic [TW-1:0]  SETTLE     = TW'(PEN_SETTLE);
  localparam logic [HW-1:0]  HIT_LAST   = HW'(PEN_HITS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_DISP, ST_PROBE} state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CLW-1:0]     slot_q, slot_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [HW-1:0]      hcnt_q;
  logic               done_q;
  logic               busy_q;
  logic [RW-1:0]      clr_row_q;
  logic [CLW-1:0]     clr_col_q;
  logic               pen_valid_q;
  logic [RW-1:0]      pen_row_q;
  logic [CLW-1:0]     pen_col_q;
  logic [COLOR_W-1:0] rd_data_q;
  logic [COLOR_W-1:0] fb [ROWS][COLS];

  logic start_clr, run, in_probe, slot_end, sample, hit, rd_in_range;

  // A starting or running sweep freezes the scan, so the sweep owns the framebuffer alone.
  assign start_clr   = bus.clear_i && !busy_q;
  assign run         = bus.en_i && !busy_q && !start_clr;
  assign in_probe    = (state_q == ST_PROBE);
  assign slot_end    = in_probe && (cnt_q == PROBE_LAST);
  assign sample      = in_probe && run && !done_q && (cnt_q >= SETTLE);
  assign hit         = sample && bus.pen_i && (hcnt_q == HIT_LAST);
  assign rd_in_range = (int'(bus.rd_row_i) < ROWS) && (int'(bus.rd_col_i) < COLS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      row_q   <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    if (!run) begin
      state_d = ST_OFF;
      row_d   = '0;
      slot_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_DISP;
        ST_DISP: begin
          if (cnt_q == DISP_LAST) begin
            state_d = ST_PROBE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PROBE: begin
          if (cnt_q == PROBE_LAST) begin
            cnt_d = '0;
            if (slot_q == COL_LAST) begin
              state_d = ST_DISP;
              slot_d  = '0;
              row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    bus.row_o = '1;
    bus.col_o = '0;
    if (state_q != ST_OFF) begin
      bus.row_o[row_q] = 1'b0;
      for (int k = 0; k < COLOR_W; k++) begin
        for (int c = 0; c < COLS; c++) begin
          bus.col_o[k*COLS + c] = in_probe ? (CLW'(c) == slot_q) : fb[row_q][c][k];
        end
      end
    end
  end

  // Pen filter: a run of consecutive high samples after settling; one hit per slot at most.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q      <= '0;
      done_q      <= 1'b0;
      pen_valid_q <= 1'b0;
      pen_row_q   <= '0;
      pen_col_q   <= '0;
    end else begin
      pen_valid_q <= hit;
      if (hit) begin
        pen_row_q <= row_q;
        pen_col_q <= slot_q;
      end
      if (!(in_probe && run) || slot_end) begin
        hcnt_q <= '0;
        done_q <= 1'b0;
      end else if (sample) begin
        hcnt_q <= bus.pen_i ? hcnt_q + 1'b1 : '0;
        if (hit) done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      clr_row_q <= '0;
      clr_col_q <= '0;
    end else if (busy_q) begin
      if (clr_col_q == COL_LAST) begin
        clr_col_q <= '0;
        if (clr_row_q == ROW_LAST) begin
          busy_q    <= 1'b0;
          clr_row_q <= '0;
        end else begin
          clr_row_q <= clr_row_q + 1'b1;
        end
      end else begin
        clr_col_q <= clr_col_q + 1'b1;
      end
    end else if (start_clr) begin
      busy_q    <= 1'b1;
      clr_row_q <= '0;
      clr_col_q <= '0;
    end
  end

  // Mode and colour are taken in the cycle the hit pulse is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          fb[r][c] <= '0;
        end
      end
    end else if (busy_q) begin
      fb[clr_row_q][clr_col_q] <= '0;
    end else if (pen_valid_q && bus.mode_i == 2'd1) begin
      fb[pen_row_q][pen_col_q] <= bus.color_i;
    end else if (pen_valid_q && bus.mode_i == 2'd2) begin
      fb[pen_row_q][pen_col_q] <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_in_range ? fb[bus.rd_row_i][bus.rd_col_i] : '0;
    end
  end

  assign bus.pen_valid_o = pen_valid_q;
  assign bus.pen_row_o   = pen_row_q;
  assign bus.pen_col_o   = pen_col_q;
  assign bus.busy_o      = busy_q;
  assign bus.rd_data_o   = rd_data_q;
endmodule

// File: tb/tb_pen_matrix_scanner.sv
// Bench for pen_matrix_scanner: directed pen scenarios plus random traffic.
// All traffic is checked every cycle against a position-arithmetic reference model.
module tb_pen_matrix_scanner;
  localparam int ROWS = 4, COLS = 4, CW = 2;
  localparam int DISP = 8, PROBE = 6, SETTLE = 2, HITS = 2;
  localparam int RP = DISP + COLS * PROBE;
  localparam int NPIX = ROWS * COLS;
  localparam int RW = $clog2(ROWS), CLW = $clog2(COLS);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pen_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .COLOR_W(CW)) bus ();

  pen_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .COLOR_W(CW), .DISP_CYC(DISP),
    .PROBE_CYC(PROBE), .PEN_SETTLE(SETTLE), .PEN_HITS(HITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position is derived from the count of active scan cycles.
  logic [CW-1:0] m_fb [ROWS][COLS];
  bit m_act, m_busy, m_valid, m_done;
  int m_t, m_ci, m_hc, m_prow, m_pcol;
  logic [CW-1:0] m_rd;

  function automatic void where(input int t, output int r, output bit probe,
                                output int slot, output int s);
    int w;
    r = (t / RP) % ROWS;
    w = t % RP;
    probe = (w >= DISP);
    slot = probe ? (w - DISP) / PROBE : 0;
    s = probe ? (w - DISP) % PROBE : w;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_fb[r][c] = '0;
    m_act = 0; m_busy = 0; m_valid = 0; m_done = 0;
    m_t = 0; m_ci = 0; m_hc = 0; m_prow = 0; m_pcol = 0; m_rd = '0;
  endtask

  task automatic model_edge();
    bit o_busy, o_valid, run, probe;
    int r, slot, s;
    o_busy = m_busy;
    o_valid = m_valid;
    run = bus.en_i && !o_busy && !bus.clear_i;
    m_rd = (int'(bus.rd_row_i) < ROWS && int'(bus.rd_col_i) < COLS) ?
           m_fb[bus.rd_row_i][bus.rd_col_i] : '0;
    if (o_valid && !o_busy) begin
      if (bus.mode_i == 2'd1) m_fb[RW'(m_prow)][CLW'(m_pcol)] = bus.color_i;
      else if (bus.mode_i == 2'd2) m_fb[RW'(m_prow)][CLW'(m_pcol)] = '0;
    end
    if (o_busy) begin
      m_fb[RW'(m_ci / COLS)][CLW'(m_ci % COLS)] = '0;
      m_ci++;
      if (m_ci == NPIX) m_busy = 0;
    end else if (bus.clear_i) begin
      m_busy = 1;
      m_ci = 0;
    end
    m_valid = 0;
    if (m_act && run) begin
      where(m_t, r, probe, slot, s);
      if (probe) begin
        if (!m_done && s >= SETTLE) begin
          if (bus.pen_i) begin
            m_hc++;
            if (m_hc == HITS) begin
              m_valid = 1; m_done = 1; m_prow = r; m_pcol = slot;
            end
          end else begin
            m_hc = 0;
          end
        end
        if (s == PROBE - 1) begin
          m_hc = 0; m_done = 0;
        end
      end
      m_t++;
    end else begin
      m_hc = 0; m_done = 0;
    end
    if (run) m_act = 1;
    else begin
      m_act = 0; m_t = 0;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] er, ec;
    int r, slot, s;
    bit probe;
    er = (32'd1 << ROWS) - 1;
    ec = '0;
    if (m_act) begin
      where(m_t, r, probe, slot, s);
      er = er & ~(32'd1 << r);
      for (int k = 0; k < CW; k++)
        for (int c = 0; c < COLS; c++)
          if (probe ? (c == slot) : (((m_fb[RW'(r)][CLW'(c)] >> k) & 1) != 0))
            ec = ec | (32'd1 << (k * COLS + c));
    end
    expect_eq("row_o", 32'(bus.row_o), er);
    expect_eq("col_o", 32'(bus.col_o), ec);
    expect_eq("pen_valid_o", 32'(bus.pen_valid_o), 32'(m_valid));
    expect_eq("pen_row_o", 32'(bus.pen_row_o), 32'(m_prow));
    expect_eq("pen_col_o", 32'(bus.pen_col_o), 32'(m_pcol));
    expect_eq("busy_o", 32'(bus.busy_o), 32'(m_busy));
    expect_eq("rd_data_o", 32'(bus.rd_data_o), 32'(m_rd));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_checks(string tag);
    expect_eq({tag, "_row"}, 32'(bus.row_o), 32'hF);
    expect_eq({tag, "_col"}, 32'(bus.col_o), 32'h0);
    expect_eq({tag, "_valid"}, 32'(bus.pen_valid_o), 32'h0);
    expect_eq({tag, "_prow"}, 32'(bus.pen_row_o), 32'h0);
    expect_eq({tag, "_pcol"}, 32'(bus.pen_col_o), 32'h0);
    expect_eq({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
    expect_eq({tag, "_rd"}, 32'(bus.rd_data_o), 32'h0);
  endtask

  function automatic bit pen_for(int pat, int tr, int tc);
    int r, slot, s;
    bit probe;
    if (!m_act) return 1'b0;
    where(m_t, r, probe, slot, s);
    if (!probe || r != tr || slot != tc) return 1'b0;
    case (pat)
      1: return (s == 2 || s == 3);
      2: return (s < 2);
      3: return (s == 2 || s == 4);
      4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One full frame with a pen pattern on one pixel, counting hit pulses.
  task automatic scenario(string tag, int pat, int tr, int tc, int exp_pulses);
    int pulses;
    pulses = 0;
    for (int i = 0; i < ROWS * RP + 2; i++) begin
      bus.pen_i = (i < ROWS * RP) ? pen_for(pat, tr, tc) : 1'b0;
      step();
      if (bus.pen_valid_o) pulses++;
    end
    bus.pen_i = 1'b0;
    expect_eq(tag, 32'(pulses), 32'(exp_pulses));
  endtask

  task automatic read_px(int r, int c, output logic [CW-1:0] v);
    bus.rd_row_i = RW'(r);
    bus.rd_col_i = CLW'(c);
    step();
    v = bus.rd_data_o;
  endtask

  task automatic read_all_zero(string tag);
    logic [CW-1:0] v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        read_px(r, c, v);
        expect_eq(tag, 32'(v), 32'h0);
      end
  endtask

  initial begin
    logic [CW-1:0] v;
    int cnt, pulses, r, slot, s;
    bit probe, found;

    bus.en_i = 0; bus.mode_i = 2'd0; bus.color_i = '0; bus.pen_i = 0;
    bus.clear_i = 0; bus.rd_row_i = '0; bus.rd_col_i = '0;
    #1 rst = 1'b1;
    model_reset();
    #11;
    reset_checks("reset");
    @(negedge clk);
    rst = 1'b0;

    repeat (4) step();
    expect_eq("en0_row", 32'(bus.row_o), 32'hF);
    expect_eq("en0_col", 32'(bus.col_o), 32'h0);

    bus.en_i = 1; bus.mode_i = 2'd1; bus.color_i = 2'b10;
    scenario("draw_pulses", 1, 1, 2, 1);
    read_px(1, 2, v);
    expect_eq("draw_rd", 32'(v), 32'h2);

    for (int i = 0; i < ROWS * RP; i++) begin
      step();
      where(m_t, r, probe, slot, s);
      if (m_act && r == 1) begin
        expect_eq("row1_drive", 32'(bus.row_o), 32'b1101);
        if (!probe) expect_eq("row1_disp_col", 32'(bus.col_o), 32'b0100_0000);
        else if (slot == 2) expect_eq("row1_probe2_col", 32'(bus.col_o), 32'b0100_0100);
      end
    end

    scenario("settle_only", 2, 1, 3, 0);
    scenario("alternating", 3, 2, 1, 0);
    bus.color_i = 2'b01;
    scenario("full_slot", 4, 3, 0, 1);
    read_px(3, 0, v);
    expect_eq("full_slot_rd", 32'(v), 32'h1);

    bus.mode_i = 2'd2;
    scenario("erase_pulses", 1, 1, 2, 1);
    read_px(1, 2, v);
    expect_eq("erase_rd", 32'(v), 32'h0);

    bus.mode_i = 2'd0;
    scenario("disp_only_pulses", 1, 3, 0, 1);
    read_px(3, 0, v);
    expect_eq("disp_only_rd", 32'(v), 32'h1);

    bus.mode_i = 2'd1; bus.color_i = 2'b11;
    scenario("draw_more", 1, 0, 0, 1);

    bus.pen_i = 1'b1;
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    cnt = 0; pulses = 0;
    for (int i = 0; i < 40 && bus.busy_o; i++) begin
      cnt++;
      if (bus.pen_valid_o) pulses++;
      step();
    end
    bus.pen_i = 1'b0;
    expect_eq("clear_busy_len", 32'(cnt), 32'(NPIX));
    expect_eq("clear_no_hit", 32'(pulses), 32'h0);
    step();
    expect_eq("restart_row0", 32'(bus.row_o), 32'b1110);
    bus.en_i = 0;
    read_all_zero("clear_rd");

    bus.en_i = 1;
    for (int i = 0; i < 3000; i++) begin
      bus.en_i = ($urandom_range(0, 199) != 0);
      bus.mode_i = 2'($urandom_range(0, 3));
      bus.color_i = CW'($urandom);
      bus.pen_i = ($urandom_range(0, 3) != 0);
      bus.clear_i = ($urandom_range(0, 299) == 0);
      bus.rd_row_i = RW'($urandom);
      bus.rd_col_i = CLW'($urandom);
      step();
    end
    bus.clear_i = 0; bus.pen_i = 0; bus.en_i = 1;
    repeat (NPIX + 2) step();

    bus.mode_i = 2'd1; bus.color_i = 2'b11;
    scenario("pre_sweep_draw", 1, 3, 3, 1);
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    repeat (5) step();
    expect_eq("sweep_busy", 32'(bus.busy_o), 32'h1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    reset_checks("rst_sweep");
    @(negedge clk);
    rst = 1'b0;
    bus.en_i = 0;
    read_all_zero("rst_sweep_rd");

    bus.en_i = 1;
    scenario("pre_probe_draw", 1, 2, 2, 1);
    found = 0;
    for (int i = 0; i < 2 * RP && !found; i++) begin
      step();
      where(m_t, r, probe, slot, s);
      found = m_act && probe;
    end
    expect_eq("reach_probe", 32'(found), 32'h1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    reset_checks("rst_probe");
    @(negedge clk);
    rst = 1'b0;
    bus.en_i = 0;
    read_all_zero("rst_probe_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pen_matrix_scanner.md
Name: pen_matrix_scanner

Overview:
- Parametrised successor of the 8x8 LED-matrix/light-pen driver.
- Time-multiplexes a ROWS x COLS multi-colour dot matrix between two phases:
  - display phase: shows the framebuffer;
  - per-pixel probe slots: light one pixel at a time so the phototransistor pen can be located.
- Pen hits are digitally filtered, written to the framebuffer in the selected mode and colour, and reported as coordinate events.
- Provides a bulk clear sweep and a registered read port for the LCD mirror.

Parameters:
- ROWS, 8, matrix rows (>=2)
- COLS, 8, matrix columns (>=2)
- COLOR_W, 2, colour channels per pixel (bit0 red, bit1 green, ...)
- DISP_CYC, 2000, clocks of display phase per row
- PROBE_CYC, 200, clocks per probe slot; must be >= PEN_SETTLE+PEN_HITS+1
- PEN_SETTLE, 50, clocks ignored at slot start (LED/pen settling)
- PEN_HITS, 20, consecutive high pen samples required for a hit

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous reset, active-high
- en_i, in, 1, scan enable
- mode_i, in, 2, 0=display only, 1=draw, 2=erase, 3=display only
- color_i, in, COLOR_W, draw colour
- pen_i, in, 1, pen detect, active-high (already inverted)
- clear_i, in, 1, start clear sweep (level or pulse)
- row_o, out, ROWS, row drive, one-hot active-low
- col_o, out, COLS*COLOR_W, column drive, active-high; channel k at [k*COLS +: COLS]
- pen_valid_o, out, 1, one-cycle hit pulse
- pen_row_o, out, $clog2(ROWS), hit row
- pen_col_o, out, $clog2(COLS), hit column
- busy_o, out, 1, clear sweep in progress
- rd_row_i, in, $clog2(ROWS), read row address
- rd_col_i, in, $clog2(COLS), read column address
- rd_data_o, out, COLOR_W, pixel value, 1-cycle latency

Behaviour:
- Reset: framebuffer all 0; scan at row 0, display phase, count 0; row_o all 1s; col_o 0; pen_valid_o 0; pen_row_o/pen_col_o 0; busy_o 0; rd_data_o 0.
- Row period = DISP_CYC + COLS*PROBE_CYC clocks. Row sequence: 0..ROWS-1, then wraps to 0.
- Display phase: row_o bit r low; col_o channel k bit c = fb[r][c][k].
- Probe slot c (c = 0..COLS-1): row_o bit r low; all channels drive column c only.
- Phase/row changes are registered. Outputs switch on the same edge the counters advance.
- Pen filter, per slot:
  - Slot cycle index s runs 0..PROBE_CYC-1.
  - For s >= PEN_SETTLE, a hit counter increments while pen_i=1 and resets to 0 when pen_i=0.
  - The counter clears at every slot start.
  - When the counter reaches PEN_HITS, a hit latches. At most one hit per slot; later samples are ignored.
- On the cycle after the hit latches:
  - pen_valid_o=1 for 1 cycle, with pen_row_o=r and pen_col_o=c; coordinates hold until the next hit.
  - mode 1: fb[r][c] <= color_i. color_i=0 is permitted and erases.
  - mode 2: fb[r][c] <= 0.
  - modes 0 and 3: no write; pen_valid_o still pulses.
  - mode_i and color_i are sampled on the write cycle.
- pen_i during the display phase is ignored.
- en_i=0:
  - row_o all 1s, col_o 0.
  - Scan counters return to row 0 / display phase / count 0.
  - No hits; a pending hit is discarded.
  - Clear and read still operate.
- Clear sweep:
  - clear_i=1 while idle: busy_o=1 next cycle.
  - One pixel is zeroed per clock in linear order row*COLS+col, taking ROWS*COLS clocks.
  - busy_o drops the cycle after the last pixel is zeroed.
  - clear_i while busy is ignored; a held level restarts the sweep after completion.
  - During the sweep: scan frozen, row_o all 1s, col_o 0, no hits.
  - After the sweep, scanning resumes at row 0 / display phase.
- Read port: rd_data_o <= fb[rd_row_i][rd_col_i] every clock. A same-cycle write returns the old value; the new value appears the following cycle.
- Out-of-range rd addresses (non-power-of-2 sizes) return 0.
- Reset mid-sweep or mid-scan returns all state to the reset values immediately.

Test Plan:
- Bench parameters: ROWS=4, COLS=4, COLOR_W=2, DISP_CYC=8, PROBE_CYC=6, PEN_SETTLE=2, PEN_HITS=2.
- Scan timing, en_i=1, pen_i=0: row period = 32 clocks, frame = 128 clocks.
  - Row 1: row_o=4'b1101.
  - Probe slot 2: col_o=8'b0100_0100.
  - row_o/col_o are all 1s/0 while en_i=0.
- Draw: mode=1, color=2'b10; pen_i high for s=2..3 in row 1, slot 2.
  - pen_valid_o pulses once, 1 cycle after s=3, with row=1, col=2.
  - Reading (1,2) returns 2'b10.
  - Display phase of row 1 then shows col_o=8'b0100_0000.
- Filter/settle:
  - pen_i high only for s=0..1: no hit.
  - pen_i pattern 1,0,1,0 from s=2: no hit.
  - pen_i high for the whole slot: exactly 1 pulse.
- Erase and display-only:
  - mode=2 on pixel (1,2): reads 0, pen_valid_o pulses.
  - mode=0: pulse occurs, framebuffer unchanged.
- Clear: pulse clear_i with several pixels set.
  - busy_o high for exactly 16 clocks; all reads return 0.
  - A pen_i hit during the sweep produces no pulse.
  - Scanning restarts at row 0.
- Reset: assert rst mid-sweep and mid-probe-slot.
  - All outputs go to reset values asynchronously; the framebuffer reads 0 afterwards.
